// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings and helpers for the MIPS pipeline control blocks.
// Provides the mult/div op codes, Tuse/Tnew width and the hazard compare helper.
package mips_ctrl_pkg;

  localparam int T_W            = 2;
  localparam int TUSE_NEVER     = 3;
  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;
  localparam int DEF_CNT_W      = 4;

  typedef enum logic [1:0] {
    MD_OP_NONE = 2'b00,
    MD_OP_MUL  = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_RSVD = 2'b11
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source stalls only if a producer still needs more cycles than the consumer can wait.
  function automatic logic hz_match(
    input logic [4:0]     addr,
    input logic [T_W-1:0] tuse,
    input logic [4:0]     e_wa,
    input logic [T_W-1:0] e_tnew,
    input logic [4:0]     m_wa,
    input logic [T_W-1:0] m_tnew
  );
    return (addr != 5'd0) &&
           (((addr == e_wa) && (tuse < e_tnew)) ||
            ((addr == m_wa) && (tuse < m_tnew)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bundle between the D/E/M stages and the stall sequencer.
// slave = sequencer side, master = pipeline (or bench) side.
interface hazard_stall_ctrl_if
  import mips_ctrl_pkg::*;
();
  logic [4:0]     D_rs_addr;
  logic [4:0]     D_rt_addr;
  logic [T_W-1:0] D_tuse_rs;
  logic [T_W-1:0] D_tuse_rt;
  logic           D_uses_md;
  logic [4:0]     E_wa;
  logic [T_W-1:0] E_tnew;
  logic [4:0]     M_wa;
  logic [T_W-1:0] M_tnew;
  logic [1:0]     E_md_op;
  logic           F_en;
  logic           D_en;
  logic           E_flush;
  logic           md_busy;
  logic [31:0]    stall_count;

  modport slave (
    input  D_rs_addr, D_rt_addr, D_tuse_rs, D_tuse_rt, D_uses_md,
    input  E_wa, E_tnew, M_wa, M_tnew, E_md_op,
    output F_en, D_en, E_flush, md_busy, stall_count
  );

  modport master (
    output D_rs_addr, D_rt_addr, D_tuse_rs, D_tuse_rt, D_uses_md,
    output E_wa, E_tnew, M_wa, M_tnew, E_md_op,
    input  F_en, D_en, E_flush, md_busy, stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// HI/LO unit busy timer: IDLE/BUSY FSM with a down-counter.
// Busy spans the start cycle (combinational on E_md_op) plus the counted cycles.
module md_busy_timer
  import mips_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] E_md_op,
  output logic       md_busy
);

  md_state_e        r_state;
  md_state_e        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_start;

  assign w_start = (E_md_op == MD_OP_MUL) || (E_md_op == MD_OP_DIV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        // Reserved op 11 falls through and leaves the unit idle.
        if (E_md_op == MD_OP_MUL) begin
          w_state_next = MD_BUSY;
          w_cnt_next   = CNT_W'(MUL_CYCLES - 1);
        end else if (E_md_op == MD_OP_DIV) begin
          w_state_next = MD_BUSY;
          w_cnt_next   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_next = MD_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = MD_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    md_busy = reset & ((r_state == MD_BUSY) | w_start);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall sequencer: register hazards (Tuse/Tnew) plus mult/div busy interlock.
// Optional stall-cycle counter enabled by defining STALL_STATS_EN.
module hazard_stall_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  logic [4:0]     w_src_addr [2];
  logic [T_W-1:0] w_src_tuse [2];
  logic [1:0]     w_reg_hz;
  logic           w_md_busy;
  logic           w_stall;

  assign w_src_addr[0] = bus.D_rs_addr;
  assign w_src_addr[1] = bus.D_rt_addr;
  assign w_src_tuse[0] = bus.D_tuse_rs;
  assign w_src_tuse[1] = bus.D_tuse_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign w_reg_hz[gi] = hz_match(w_src_addr[gi], w_src_tuse[gi],
                                     bus.E_wa, bus.E_tnew, bus.M_wa, bus.M_tnew);
    end
  endgenerate

  md_busy_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .E_md_op (bus.E_md_op),
    .md_busy (w_md_busy)
  );

  // Held in reset the pipeline free-runs: no stall may leak out.
  assign w_stall = reset & ((|w_reg_hz) | (bus.D_uses_md & w_md_busy));

  assign bus.F_en    = ~w_stall;
  assign bus.D_en    = ~w_stall;
  assign bus.E_flush = w_stall;
  assign bus.md_busy = w_md_busy;

`ifdef STALL_STATS_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.stall_count = r_stall_count;
`else
  assign bus.stall_count = 32'h0;
`endif

endmodule
